// File: rtl/seq_shift_add_mult_pkg.sv
// Shared constants for the KGP ALU multiplier slice.
// Holds the control-state encodings and the default operand width.
package kgp_alu_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/cla_nbit_adder.sv
// WIDTH-bit carry-lookahead adder made of chained 4-bit lookahead slices.
// Purely combinational; the carry between slices ripples slice to slice.
module cla_nbit_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NSLICE = WIDTH / 4;

  logic [NSLICE:0] slice_c_s;

  assign slice_c_s[0] = cin;
  assign cout         = slice_c_s[NSLICE];

  for (genvar i = 0; i < NSLICE; i++) begin : g_slice
    logic [3:0] g_s;
    logic [3:0] p_s;
    logic [4:0] c_s;

    assign g_s = a[4*i +: 4] & b[4*i +: 4];
    assign p_s = a[4*i +: 4] ^ b[4*i +: 4];

    // Every carry is derived from the slice carry-in, not from its neighbour.
    assign c_s[0] = slice_c_s[i];
    assign c_s[1] = g_s[0] | (p_s[0] & c_s[0]);
    assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & c_s[0]);
    assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                  | (p_s[2] & p_s[1] & p_s[0] & c_s[0]);
    assign c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                  | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                  | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & c_s[0]);

    assign sum[4*i +: 4]    = p_s ^ c_s[3:0];
    assign slice_c_s[i + 1] = c_s[4];
  end

endmodule

// File: rtl/seq_shift_add_mult.sv
// Iterative unsigned shift-and-add multiplier: WIDTH iterations per product,
// start/busy/done handshake, one shared CLA for the accumulate step.
module seq_shift_add_mult
  import kgp_alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);

  logic [1:0]         state_r;
  logic [1:0]         next_state_s;
  logic [CW-1:0]      cnt_r;
  logic [WIDTH-1:0]   mcand_r;
  logic [2*WIDTH-1:0] acc_r;
  logic               busy_r;
  logic               done_r;
  logic               accept_s;
  logic [WIDTH-1:0]   addend_s;
  logic [WIDTH-1:0]   sum_s;
  logic               carry_s;

  assign accept_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign addend_s = acc_r[0] ? mcand_r : {WIDTH{1'b0}};

  cla_nbit_adder #(.WIDTH(WIDTH)) u_cla (
    .a    (acc_r[2*WIDTH-1:WIDTH]),
    .b    (addend_s),
    .cin  (1'b0),
    .sum  (sum_s),
    .cout (carry_s)
  );

  // Next-state selection; the unused encoding falls back to IDLE.
  always_comb begin
    next_state_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) next_state_s = ST_RUN;
        else          next_state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (cnt_r == CNT_ONE) next_state_s = ST_DONE;
        else                  next_state_s = ST_RUN;
      end
      ST_DONE: begin
        if (accept_s) next_state_s = ST_RUN;
        else          next_state_s = ST_IDLE;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State plus handshake flags, registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s == ST_RUN);
      done_r  <= (next_state_s == ST_DONE);
    end
  end

  // Operand capture and one shift-add iteration per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_r <= {WIDTH{1'b0}};
      acc_r   <= {(2*WIDTH){1'b0}};
      cnt_r   <= {CW{1'b0}};
    end else if (accept_s) begin
      mcand_r <= a;
      acc_r   <= {{WIDTH{1'b0}}, b};
      cnt_r   <= CNT_LOAD;
    end else if (state_r == ST_RUN) begin
      // Carry-out re-enters at the MSB so the full product is kept.
      acc_r   <= {carry_s, sum_s, acc_r[WIDTH-1:1]};
      cnt_r   <= cnt_r - CNT_ONE;
    end else begin
      mcand_r <= mcand_r;
      acc_r   <= acc_r;
      cnt_r   <= cnt_r;
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = acc_r;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Scoreboard bench for seq_shift_add_mult: stimulus pushes expected product and
// done cycle, a negedge monitor pops and compares on every done pulse.
module tb_seq_shift_add_mult;

  localparam int W = 32;

  typedef struct {
    logic [2*W-1:0] prod;
    int             cyc;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int   cyc;
  int   checks;
  int   failures;
  exp_t sb[$];

  seq_shift_add_mult #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=done expected=no_done (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("product", product, e.prod);
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
        chk("busy_at_done", {63'd0, busy}, 64'd0);
      end
    end
  end

  task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit hold);
    exp_t e;
    @(negedge clk); #1;
    a = av;
    b = bv;
    start = 1'b1;
    e.prod = 64'(av) * 64'(bv);
    e.cyc  = cyc + 1 + W;
    sb.push_back(e);
    if (!hold) begin
      @(negedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk); #1;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout actual=pending_%0d expected=pending_0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    exp_t e;
    cyc      = 0;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_product", product, 64'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;

    op(32'd3, 32'd5, 1'b0);
    @(negedge clk); #1;
    chk("busy_in_run", {63'd0, busy}, 64'd1);
    wait_idle();

    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_idle();

    op(32'h0000_0000, 32'h1234_5678, 1'b0);
    wait_idle();
    op(32'h8000_0000, 32'h0000_0002, 1'b0);
    wait_idle();
    @(negedge clk); #1;
    chk("product_held", product, 64'h0000_0001_0000_0000);

    // Second start lands mid-run and must be ignored.
    op(32'd7, 32'd6, 1'b0);
    repeat (9) begin @(negedge clk); #1; end
    chk("busy_before_reject", {63'd0, busy}, 64'd1);
    a = 32'd9;
    b = 32'd9;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    wait_idle();

    // Asynchronous reset in the middle of a run discards the operation.
    op(32'd5, 32'd5, 1'b0);
    repeat (14) begin @(negedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_busy", {63'd0, busy}, 64'd0);
    chk("midrun_rst_done", {63'd0, done}, 64'd0);
    chk("midrun_rst_product", product, 64'd0);
    sb.delete();
    @(negedge clk); #1;
    rst_n = 1'b1;
    op(32'd2, 32'd2, 1'b0);
    wait_idle();

    // Back-to-back: start held high, new operands presented in the done cycle.
    op(32'd10, 32'd10, 1'b1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (done) break;
    end
    chk("b2b_first_done_seen", {63'd0, done}, 64'd1);
    a = 32'd11;
    b = 32'd11;
    e.prod = 64'd121;
    e.cyc  = cyc + 1 + W;
    sb.push_back(e);
    @(negedge clk); #1;
    start = 1'b0;
    wait_idle();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
